// File: rtl/mii_rx_framer.sv
// mii_rx_framer: MII nibble receiver that strips preamble/SFD, assembles bytes, and reports CRC/length/alignment/PHY status per frame.
module mii_rx_framer #(
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1522
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mii_rx_dv,
  input  logic       mii_rx_er,
  input  logic [3:0] mii_rxd,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_sof,
  output logic       out_eof,
  output logic       frame_done,
  output logic       frame_good,
  output logic       err_crc,
  output logic       err_len,
  output logic       err_align,
  output logic       err_phy
);
  localparam logic [1:0] DROP = 2'd0, IDLE = 2'd1, PREAMBLE = 2'd2, DATA = 2'd3;
  localparam logic [10:0] MIN_C = 11'(MIN_FRAME_BYTES);
  localparam logic [10:0] MAX_C = 11'(MAX_FRAME_BYTES);
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
  logic [1:0]  state;
  logic        phase;
  logic [3:0]  lo;
  logic [10:0] cnt;
  logic [31:0] crc;
  logic [7:0]  held;
  logic        held_v;
  logic        held_first;
  logic        phy;
  logic [7:0]  byte_in;
  logic        phy_n;
  logic        short_n;
  logic        crc_bad;
  logic        trunc;
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction
  always_comb begin
    byte_in = {mii_rxd, lo};
    phy_n   = phy | mii_rx_er;
    short_n = cnt < MIN_C;
    crc_bad = crc != RESIDUE;
    trunc   = phase && cnt == MAX_C;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= DROP;
      phase      <= 1'b0;
      lo         <= 4'd0;
      cnt        <= 11'd0;
      crc        <= '1;
      held       <= 8'd0;
      held_v     <= 1'b0;
      held_first <= 1'b0;
      phy        <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= 8'd0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      frame_done <= 1'b0;
      frame_good <= 1'b0;
      err_crc    <= 1'b0;
      err_len    <= 1'b0;
      err_align  <= 1'b0;
      err_phy    <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      frame_done <= 1'b0;
      frame_good <= 1'b0;
      err_crc    <= 1'b0;
      err_len    <= 1'b0;
      err_align  <= 1'b0;
      err_phy    <= 1'b0;
      case (state)
        DROP: if (!mii_rx_dv) state <= IDLE;
        IDLE: if (mii_rx_dv) state <= (mii_rxd == 4'h5) ? PREAMBLE : DROP;
        PREAMBLE:
          if (!mii_rx_dv) state <= IDLE;
          else if (mii_rxd == 4'hD) begin
            state  <= DATA;
            phase  <= 1'b0;
            cnt    <= 11'd0;
            phy    <= 1'b0;
            held_v <= 1'b0;
            crc    <= '1;
          end else if (mii_rxd != 4'h5) state <= DROP;
        DATA:
          if (!mii_rx_dv) begin
            out_valid  <= held_v;
            if (held_v) out_data <= held;
            out_sof    <= held_v & held_first;
            out_eof    <= 1'b1;
            frame_done <= 1'b1;
            err_align  <= phase;
            err_len    <= short_n;
            err_crc    <= crc_bad;
            err_phy    <= phy;
            frame_good <= !(phase || short_n || crc_bad || phy);
            state      <= IDLE;
          end else begin
            phy <= phy_n;
            if (!phase) begin
              lo    <= mii_rxd;
              phase <= 1'b1;
            end else if (trunc) begin
              // Byte MAX+1 is dropped; the frame closes on the byte already held.
              out_valid  <= held_v;
              if (held_v) out_data <= held;
              out_sof    <= held_v & held_first;
              out_eof    <= 1'b1;
              frame_done <= 1'b1;
              err_len    <= 1'b1;
              err_phy    <= phy_n;
              state      <= DROP;
            end else begin
              phase      <= 1'b0;
              crc        <= crc_byte(crc, byte_in);
              cnt        <= (cnt == 11'h7FF) ? cnt : cnt + 11'd1;
              out_valid  <= held_v;
              if (held_v) out_data <= held;
              out_sof    <= held_v & held_first;
              held       <= byte_in;
              held_v     <= 1'b1;
              held_first <= cnt == 11'd0;
            end
          end
      endcase
    end
  end
endmodule

// File: tb/tb_mii_rx_framer.sv
// tb_mii_rx_framer: randomized scoreboard bench for mii_rx_framer against a frame-level reference model.
module tb_mii_rx_framer;
  localparam int MAXB = 1522;
  logic       clk = 1'b0;
  logic       rst;
  logic       mii_rx_dv;
  logic       mii_rx_er;
  logic [3:0] mii_rxd;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_sof;
  logic       out_eof;
  logic       frame_done;
  logic       frame_good;
  logic       err_crc;
  logic       err_len;
  logic       err_align;
  logic       err_phy;
  logic [9:0] bq[$];
  logic [4:0] sq[$];
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  mii_rx_framer dut (
    .clk(clk), .rst(rst), .mii_rx_dv(mii_rx_dv), .mii_rx_er(mii_rx_er), .mii_rxd(mii_rxd),
    .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof),
    .frame_done(frame_done), .frame_good(frame_good), .err_crc(err_crc), .err_len(err_len),
    .err_align(err_align), .err_phy(err_phy)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Standard Ethernet CRC over the first len bytes, returned as the FCS value.
  function automatic logic [31:0] fcs(input logic [7:0] d[$], input int len);
    logic [31:0] c = '1;
    for (int i = 0; i < len; i++) begin
      c ^= {24'd0, d[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    end
    return ~c;
  endfunction
  task automatic make_frame(input int plen, output logic [7:0] q[$]);
    logic [31:0] f;
    q = {};
    for (int i = 0; i < plen; i++) q.push_back(8'($urandom));
    f = fcs(q, plen);
    for (int i = 0; i < 4; i++) q.push_back(f[8*i +: 8]);
  endtask
  task automatic drive(input logic dv, input logic [3:0] d, input logic e, input logic r);
    @(posedge clk);
    #1;
    mii_rx_dv = dv;
    mii_rxd   = d;
    mii_rx_er = e;
    rst       = r;
  endtask
  // Expectations come from frame-level rules; then the frame is driven as nibbles.
  task automatic send_frame(input logic [7:0] d[$], input bit bad_pre, input bit extra,
                            input int er_nib, input int rst_byte);
    int n = d.size();
    int m = n > MAXB ? MAXB : n;
    logic ok, ln, ph;
    if (!bad_pre) begin
      if (rst_byte >= 0) begin
        for (int i = 0; i < rst_byte - 1; i++) bq.push_back({i == 0, 1'b0, d[i]});
      end else begin
        for (int i = 0; i < m; i++) bq.push_back({i == 0, i == m - 1, d[i]});
        if (n > MAXB) begin
          ph = er_nib >= 0 && er_nib < 2 * MAXB + 2;
          sq.push_back({1'b0, 1'b0, 1'b1, 1'b0, ph});
        end else begin
          ok = n >= 4 && fcs(d, n - 4) == {d[n-1], d[n-2], d[n-3], d[n-4]};
          ln = n < 64;
          ph = er_nib >= 0;
          sq.push_back({ok && !ln && !extra && !ph, !ok, ln, extra, ph});
        end
      end
    end
    for (int i = 0; i < 7; i++) drive(1'b1, (bad_pre && i == 3) ? 4'h7 : 4'h5, 1'b0, 1'b0);
    drive(1'b1, 4'hD, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, d[i][3:0], er_nib == 2 * i, rst_byte == i);
      drive(1'b1, d[i][7:4], er_nib == 2 * i + 1, 1'b0);
    end
    if (extra) drive(1'b1, 4'($urandom), 1'b0, 1'b0);
    repeat (1 + $urandom_range(0, 2)) drive(1'b0, 4'h0, 1'b0, 1'b0);
  endtask
  always @(negedge clk) begin
    if (out_valid) begin
      if (bq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_byte: got data %h sof %b eof %b, none expected", out_data, out_sof, out_eof);
      end else check("byte {sof,eof,data}", {22'd0, out_sof, out_eof, out_data}, {22'd0, bq.pop_front()});
    end else if (out_sof || out_eof) check("stray_sof_eof", {30'd0, out_sof, out_eof}, 32'd0);
    if (frame_done) begin
      if (sq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_status: got good/crc/len/align/phy %b%b%b%b%b, none expected",
                 frame_good, err_crc, err_len, err_align, err_phy);
      end else check("status {good,crc,len,align,phy}",
                     {27'd0, frame_good, err_crc, err_len, err_align, err_phy}, {27'd0, sq.pop_front()});
    end
  end
  initial begin
    logic [7:0] f[$], g[$], s[$], l[$], r[$];
    rst = 1'b1;
    mii_rx_dv = 1'b0;
    mii_rx_er = 1'b0;
    mii_rxd = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_sof_eof", {30'd0, out_sof, out_eof}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_status", {27'd0, frame_good, err_crc, err_len, err_align, err_phy}, 32'd0);
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    make_frame(60, f);
    send_frame(f, 1'b0, 1'b0, -1, -1);
    g = f;
    g[10] = g[10] ^ 8'h08;
    send_frame(g, 1'b0, 1'b0, -1, -1);
    make_frame(36, s);
    send_frame(s, 1'b0, 1'b0, -1, -1);
    send_frame(s, 1'b0, 1'b1, -1, -1);
    send_frame(f, 1'b0, 1'b0, 61, -1);
    send_frame(f, 1'b1, 1'b0, -1, -1);
    send_frame(f, 1'b0, 1'b0, -1, -1);
    send_frame(f, 1'b0, 1'b0, -1, 20);
    send_frame(f, 1'b0, 1'b0, -1, -1);
    make_frame(1526, l);
    send_frame(l, 1'b0, 1'b0, -1, -1);
    send_frame(f, 1'b0, 1'b0, -1, -1);
    for (int k = 0; k < 24; k++) begin
      make_frame($urandom_range(10, 100), r);
      if ($urandom_range(0, 2) == 0) r[$urandom_range(0, 9)] ^= 8'h01;
      send_frame(r, 1'b0, $urandom_range(0, 3) == 0,
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2 * r.size() - 1) : -1, -1);
    end
    repeat (10) drive(1'b0, 4'h0, 1'b0, 1'b0);
    check("bytes_outstanding", bq.size(), 32'd0);
    check("status_outstanding", sq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
